// File: rtl/tdc_stream_arb_if.sv
// Stream bundle between the TDC array and Core_Control: NCH input lanes in, one tagged merged stream out.
interface tdc_stream_arb_if #(
  parameter int NCH = 4,
  parameter int DW  = 15,
  parameter int CW  = (NCH > 2) ? $clog2(NCH) : 1
);
  logic [NCH*DW-1:0] tdc_odata;
  logic [NCH*2-1:0]  tdc_onum;
  logic [NCH-1:0]    tdc_olast;
  logic [NCH-1:0]    tdc_ovalid;
  logic [NCH-1:0]    tdc_oready;
  logic [DW-1:0]     m_data;
  logic [1:0]        m_num;
  logic [CW-1:0]     m_ch;
  logic              m_last;
  logic              m_err;
  logic              m_valid;
  logic              m_ready;

  modport master (
    output tdc_odata, tdc_onum, tdc_olast, tdc_ovalid,
    input  tdc_oready,
    input  m_data, m_num, m_ch, m_last, m_err, m_valid,
    output m_ready
  );

  modport slave (
    input  tdc_odata, tdc_onum, tdc_olast, tdc_ovalid,
    output tdc_oready,
    output m_data, m_num, m_ch, m_last, m_err, m_valid,
    input  m_ready
  );
endinterface

// File: rtl/tdc_stream_arb.sv
// Multi-channel TDC frame aggregator with per-channel FIFOs and round-robin frame arbitration.
// Optional stuck-frame abort is enabled by defining TDC_ARB_TIMEOUT_EN.

// Generic FIFO with registered full/empty flags.
// Latency: a push is visible at the head (empty low) one cycle later.
// Backpressure: pushes while full and pops while empty are ignored.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   cnt;
  logic [AW:0]   cnt_nxt;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr];

  always_comb begin
    cnt_nxt = cnt;
    case ({do_push, do_pop})
      2'b10:   cnt_nxt = cnt + 1'b1;
      2'b01:   cnt_nxt = cnt - 1'b1;
      default: cnt_nxt = cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      cnt   <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      cnt   <= cnt_nxt;
      full  <= (cnt_nxt == (AW+1)'(DEPTH));
      empty <= (cnt_nxt == '0);
    end
  end
endmodule

// Merges NCH TDC streams into one channel-tagged stream, forwarding whole frames atomically.
// Latency: 3 cycles from input accept to m_valid on an idle arbiter; one bubble between frames.
// Backpressure: per-channel ready = FIFO not full; output register holds while m_valid && !m_ready.
module tdc_stream_arb #(
  parameter int NCH        = 4,
  parameter int DW         = 15,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  tdc_stream_arb_if.slave bus
);
  localparam int CW = (NCH > 2) ? $clog2(NCH) : 1;
  localparam int EW = DW + 3;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]    state;
  logic [CW-1:0] gnt;
  logic [CW-1:0] rr_ptr;
  logic [CW-1:0] pick;
  logic          any_req;
  int            idx;

  logic [NCH-1:0] push;
  logic [NCH-1:0] pop_ch;
  logic [NCH-1:0] full;
  logic [NCH-1:0] empty;
  logic [NCH-1:0] discard;
  logic [EW-1:0]  in_beat  [NCH];
  logic [EW-1:0]  head_arr [NCH];

  logic [EW-1:0]  head;
  logic           head_last;
  logic           empty_gnt;
  logic           can_load;
  logic           pop;
  logic           to_fire;

  logic           vld_q;
  logic           last_q;
  logic [1:0]     num_q;
  logic [DW-1:0]  data_q;
  logic [CW-1:0]  ch_q;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign in_beat[i]        = {bus.tdc_olast[i], bus.tdc_onum[i*2 +: 2], bus.tdc_odata[i*DW +: DW]};
    assign bus.tdc_oready[i] = !full[i];
    assign push[i]           = bus.tdc_ovalid[i] && !full[i] && !discard[i];
    assign pop_ch[i]         = pop && (gnt == CW'(i));

    sync_fifo #(
      .W     (EW),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[i]),
      .din   (in_beat[i]),
      .pop   (pop_ch[i]),
      .dout  (head_arr[i]),
      .full  (full[i]),
      .empty (empty[i])
    );
  end

  assign head      = head_arr[gnt];
  assign head_last = head[EW-1];
  assign empty_gnt = empty[gnt];
  assign can_load  = !vld_q || bus.m_ready;
  assign pop       = (state == GRANT) && !empty_gnt && can_load;

  // First non-empty channel after the last served one, wrapping modulo NCH.
  always_comb begin
    any_req = 1'b0;
    pick    = '0;
    idx     = 0;
    for (int k = 1; k <= NCH; k++) begin
      idx = (int'(rr_ptr) + k) % NCH;
      if (!any_req && !empty[idx]) begin
        any_req = 1'b1;
        pick    = CW'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      gnt    <= '0;
      rr_ptr <= CW'(NCH - 1);
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt   <= pick;
            state <= GRANT;
          end
        end
        GRANT: begin
          if ((pop && head_last) || to_fire) begin
            rr_ptr <= gnt;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      last_q <= 1'b0;
      num_q  <= '0;
      data_q <= '0;
      ch_q   <= '0;
    end else if (to_fire) begin
      vld_q  <= 1'b1;
      last_q <= 1'b1;
      num_q  <= '0;
      data_q <= '0;
      ch_q   <= gnt;
    end else if (pop) begin
      vld_q  <= 1'b1;
      last_q <= head_last;
      num_q  <= head[DW +: 2];
      data_q <= head[DW-1:0];
      ch_q   <= gnt;
    end else if (can_load) begin
      vld_q  <= 1'b0;
    end
  end

  assign bus.m_valid = vld_q;
  assign bus.m_last  = last_q;
  assign bus.m_num   = num_q;
  assign bus.m_data  = data_q;
  assign bus.m_ch    = ch_q;

`ifdef TDC_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0]  to_cnt;
  logic [NCH-1:0] drop;
  logic           err_q;

  assign to_fire = (state == GRANT) && empty_gnt && (to_cnt == TW'(TIMEOUT)) && can_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (state == IDLE || pop) begin
      to_cnt <= '0;
    end else if (empty_gnt && to_cnt != TW'(TIMEOUT)) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  // The abort cycle itself already discards, so a beat racing the abort never lands in the FIFO.
  for (genvar i = 0; i < NCH; i++) begin : g_drop
    assign discard[i] = drop[i] || (to_fire && gnt == CW'(i));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        drop[i] <= 1'b0;
      end else if (discard[i] && bus.tdc_ovalid[i] && !full[i] && bus.tdc_olast[i]) begin
        drop[i] <= 1'b0;
      end else if (to_fire && gnt == CW'(i)) begin
        drop[i] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       err_q <= 1'b0;
    else if (to_fire) err_q <= 1'b1;
    else if (pop)     err_q <= 1'b0;
  end

  assign bus.m_err = err_q;
`else
  assign to_fire   = 1'b0;
  assign discard   = '0;
  assign bus.m_err = 1'b0;
`endif
endmodule

// File: tb/tb_tdc_stream_arb.sv
// Randomized and directed bench for tdc_stream_arb against a per-channel queue scoreboard.
module tb_tdc_stream_arb;
  localparam int NCH = 4;
  localparam int DW  = 15;
  localparam int CW  = 2;

  typedef struct packed {
    logic          last;
    logic [1:0]    num;
    logic [DW-1:0] data;
  } beat_t;

  typedef struct {
    int    ch;
    beat_t b;
    int    cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #2 clk = ~clk;

  tdc_stream_arb_if #(.NCH(NCH), .DW(DW), .CW(CW)) bus ();

  tdc_stream_arb #(
    .NCH        (NCH),
    .DW         (DW),
    .FIFO_DEPTH (4),
    .TIMEOUT    (64)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  beat_t          drv_q [NCH][$];
  beat_t          exp_q [NCH][$];
  ev_t            out_log[$];
  ev_t            acc_log[$];
  logic [NCH-1:0] rdy_seen = '0;
  int             cyc = 0;
  int             gap_pct = 0;
  bit             rand_rdy = 0;
  bit             rdy_force = 1;
  int             n_chk = 0;
  int             n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic send(input int ch, input int n, input int base);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.data = DW'(base + k);
      b.num  = 2'(k);
      b.last = (k == n - 1);
      drv_q[ch].push_back(b);
    end
  endtask

  function automatic bit all_idle();
    for (int ch = 0; ch < NCH; ch++)
      if (drv_q[ch].size() != 0 || exp_q[ch].size() != 0) return 1'b0;
    return (bus.tdc_ovalid == '0) && !bus.m_valid;
  endfunction

  task automatic drain(input int maxc);
    int n;
    n = 0;
    while (!all_idle() && n < maxc) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_done", 32'(all_idle()), 32'd1);
    repeat (2) @(posedge clk);
  endtask

  task automatic clear_logs();
    out_log.delete();
    acc_log.delete();
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Driver: sole writer of the DUT inputs; inputs change 1 time unit after the rising edge.
  initial begin
    beat_t b;
    bus.tdc_ovalid = '0;
    bus.tdc_odata  = '0;
    bus.tdc_onum   = '0;
    bus.tdc_olast  = '0;
    bus.m_ready    = 1'b1;
    forever begin
      @(posedge clk); #1;
      for (int ch = 0; ch < NCH; ch++) begin
        if (!rst_n) begin
          bus.tdc_ovalid[ch] = 1'b0;
        end else begin
          if (bus.tdc_ovalid[ch] && rdy_seen[ch]) bus.tdc_ovalid[ch] = 1'b0;
          if (!bus.tdc_ovalid[ch] && drv_q[ch].size() > 0 && $urandom_range(99) >= gap_pct) begin
            b = drv_q[ch].pop_front();
            bus.tdc_odata[ch*DW +: DW] = b.data;
            bus.tdc_onum[ch*2 +: 2]    = b.num;
            bus.tdc_olast[ch]          = b.last;
            bus.tdc_ovalid[ch]         = 1'b1;
          end
        end
      end
      bus.m_ready = rand_rdy ? ($urandom_range(99) < 60) : rdy_force;
    end
  end

  // Monitor/scoreboard: every output beat must be the oldest accepted beat of its channel.
  initial begin
    bit            prev_hold;
    logic [31:0]   prev_word;
    bit            in_frame;
    int            frame_ch;
    int            c;
    beat_t         b;
    beat_t         e;
    prev_hold = 0;
    prev_word = '0;
    in_frame  = 0;
    frame_ch  = 0;
    forever begin
      @(negedge clk);
      rdy_seen = bus.tdc_oready;
      if (!rst_n) begin
        prev_hold = 0;
        in_frame  = 0;
      end else begin
        for (int ch = 0; ch < NCH; ch++) begin
          if (bus.tdc_ovalid[ch] && bus.tdc_oready[ch]) begin
            b.data = bus.tdc_odata[ch*DW +: DW];
            b.num  = bus.tdc_onum[ch*2 +: 2];
            b.last = bus.tdc_olast[ch];
            exp_q[ch].push_back(b);
            acc_log.push_back('{ch, b, cyc});
          end
        end
        if (prev_hold) begin
          check("hold_valid", 32'(bus.m_valid), 32'd1);
          check("hold_beat", {12'd0, bus.m_ch, bus.m_last, bus.m_num, bus.m_data}, prev_word);
        end
        if (bus.m_valid && bus.m_ready) begin
          c = int'(bus.m_ch);
          b = {bus.m_last, bus.m_num, bus.m_data};
          if (exp_q[c].size() == 0) begin
            check("spurious_beat", 32'(b), 32'hFFFF_FFFF);
          end else begin
            e = exp_q[c].pop_front();
            check("out_beat", 32'(b), 32'(e));
          end
          check("m_err", 32'(bus.m_err), 32'd0);
          if (in_frame) check("frame_atomic", 32'(c), 32'(frame_ch));
          in_frame = !bus.m_last;
          frame_ch = c;
          out_log.push_back('{c, b, cyc});
        end
        prev_hold = bus.m_valid && !bus.m_ready;
        prev_word = {12'd0, bus.m_ch, bus.m_last, bus.m_num, bus.m_data};
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    beat_t b;

    // Reset values
    #1;
    check("rst_m_valid", 32'(bus.m_valid), 32'd0);
    check("rst_oready", 32'(bus.tdc_oready), 32'hF);
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_data", 32'(bus.m_data), 32'd0);
    check("rst_m_num", 32'(bus.m_num), 32'd0);
    check("rst_m_ch", 32'(bus.m_ch), 32'd0);
    check("rst_m_last", 32'(bus.m_last), 32'd0);
    check("rst_m_err", 32'(bus.m_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Round-robin: all channels request in the same cycle
    @(negedge clk);
    clear_logs();
    for (int ch = 0; ch < NCH; ch++) send(ch, 1, 'h100 + ch);
    drain(200);
    check("rr4_count", 32'(out_log.size()), 32'd4);
    if (out_log.size() == 4) begin
      for (int i = 0; i < 4; i++) check("rr4_order", 32'(out_log[i].ch), 32'(i));
      for (int i = 1; i < 4; i++) check("rr4_bubble", 32'(out_log[i].cyc - out_log[i-1].cyc), 32'd2);
    end
    @(negedge clk);
    clear_logs();
    send(1, 1, 'h201);
    send(3, 1, 'h203);
    drain(200);
    check("rr2_count", 32'(out_log.size()), 32'd2);
    if (out_log.size() == 2) begin
      check("rr2_first", 32'(out_log[0].ch), 32'd1);
      check("rr2_second", 32'(out_log[1].ch), 32'd3);
    end

    // Single frame latency and framing on channel 0
    @(negedge clk);
    clear_logs();
    send(0, 1, 'h11);
    send(0, 1, 'h22);
    send(0, 1, 'h33);
    foreach (drv_q[0][i]) drv_q[0][i].last = (i == 2);
    drain(200);
    check("single_count", 32'(out_log.size()), 32'd3);
    if (out_log.size() == 3 && acc_log.size() == 3) begin
      check("single_latency", 32'(out_log[0].cyc - acc_log[0].cyc), 32'd3);
      for (int i = 0; i < 3; i++) begin
        check("single_data", 32'(out_log[i].b.data), 32'h11 * (i + 1));
        check("single_last", 32'(out_log[i].b.last), 32'(i == 2));
        check("single_ch", 32'(out_log[i].ch), 32'd0);
      end
      for (int i = 1; i < 3; i++) check("single_back2back", 32'(out_log[i].cyc - out_log[i-1].cyc), 32'd1);
    end

    // Backpressure capacity: FIFO depth plus the output register
    @(negedge clk);
    clear_logs();
    rdy_force = 0;
    send(2, 8, 'h300);
    repeat (20) @(posedge clk);
    #1;
    check("bp_accepted", 32'(acc_log.size()), 32'd5);
    check("bp_oready2", 32'(bus.tdc_oready[2]), 32'd0);
    check("bp_m_valid", 32'(bus.m_valid), 32'd1);
    check("bp_m_data", 32'(bus.m_data), 32'h300);
    rdy_force = 1;
    drain(200);
    check("bp_count", 32'(out_log.size()), 32'd8);
    if (out_log.size() == 8) check("bp_last_data", 32'(out_log[7].b.data), 32'h307);

    // Frame atomicity: channel 1 waits out channel 0's gapped frame
    @(negedge clk);
    clear_logs();
    send(0, 1, 'h400);
    drv_q[0][0].last = 1'b0;
    n = 0;
    while (acc_log.size() == 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("atom_first_accept", 32'(acc_log.size()), 32'd1);
    @(posedge clk); #1;
    send(1, 2, 'h410);
    repeat (5) @(posedge clk);
    b.data = DW'('h401);
    b.num  = 2'd1;
    b.last = 1'b1;
    drv_q[0].push_back(b);
    drain(200);
    check("atom_count", 32'(out_log.size()), 32'd4);
    if (out_log.size() == 4) begin
      check("atom_ch0a", 32'(out_log[0].ch), 32'd0);
      check("atom_ch0b", 32'(out_log[1].ch), 32'd0);
      check("atom_ch0_last", 32'(out_log[1].b.last), 32'd1);
      check("atom_ch1", 32'(out_log[2].ch), 32'd1);
      check("atom_gap", 32'(out_log[1].cyc - out_log[0].cyc >= 5), 32'd1);
    end

    // Random traffic with random downstream stalls
    @(negedge clk);
    clear_logs();
    gap_pct  = 30;
    rand_rdy = 1;
    for (int t = 0; t < 1500; t++) begin
      @(posedge clk); #1;
      for (int ch = 0; ch < NCH; ch++) begin
        if (drv_q[ch].size() == 0 && $urandom_range(99) < 25) begin
          n = $urandom_range(4, 1);
          for (int k = 0; k < n; k++) begin
            b.data = DW'($urandom);
            b.num  = 2'($urandom);
            b.last = (k == n - 1);
            drv_q[ch].push_back(b);
          end
        end
      end
    end
    rand_rdy  = 0;
    rdy_force = 1;
    gap_pct   = 0;
    drain(2000);
    check("rand_balance", 32'(out_log.size()), 32'(acc_log.size()));
    check("rand_activity", 32'(out_log.size() > 100), 32'd1);

    // Reset in the middle of a granted, buffered frame
    @(negedge clk);
    clear_logs();
    rdy_force = 0;
    send(0, 6, 'h500);
    n = 0;
    while (!bus.m_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("mid_granted", 32'(bus.m_valid), 32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    for (int ch = 0; ch < NCH; ch++) begin
      drv_q[ch].delete();
      exp_q[ch].delete();
    end
    #1;
    check("mid_rst_m_valid", 32'(bus.m_valid), 32'd0);
    check("mid_rst_oready", 32'(bus.tdc_oready), 32'hF);
    repeat (2) @(posedge clk);
    rdy_force = 1;
    @(negedge clk);
    for (int ch = 0; ch < NCH; ch++) exp_q[ch].delete();
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    clear_logs();
    send(0, 2, 'h600);
    send(2, 1, 'h620);
    drain(200);
    check("post_rst_count", 32'(out_log.size()), 32'd3);
    if (out_log.size() == 3) begin
      check("post_rst_first_ch", 32'(out_log[0].ch), 32'd0);
      check("post_rst_first_data", 32'(out_log[0].b.data), 32'h600);
      check("post_rst_third_ch", 32'(out_log[2].ch), 32'd2);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
